// File: rtl/fir_window_gen.sv
// fir_window_gen: loads the filter taps into one fir_filter_2d PE, then cuts the raster slice into 3x3 windows
// (zero padded, or edge replicated when WIN_BORDER_REPLICATE_EN is defined).
// Latency: a window is valid 1 cycle after its last pixel is accepted. Pixels stall once W+2 ahead of the issue point.
module fir_window_gen #(
  parameter int IMAGE_WIDTH  = 1920,
  parameter int IMAGE_HEIGHT = 270,
  parameter int RGB_SIZE     = 24,
  parameter int FILTER_SIZE  = 9,
  parameter int ISSUE_GAP    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [8*FILTER_SIZE-1:0]        taps,
  input  logic [RGB_SIZE-1:0]             pix_data,
  input  logic                            pix_valid,
  output logic                            pix_ready,
  output logic [RGB_SIZE*FILTER_SIZE-1:0] input_data,
  output logic                            valid_dmac,
  output logic                            tc_set,
  output logic                            busy,
  output logic                            done
);
  localparam int W     = IMAGE_WIDTH;
  localparam int H     = IMAGE_HEIGHT;
  localparam int NPIX  = W * H;
  localparam int CW    = $clog2(NPIX + 1);
  localparam int XW    = CW + 2;
  // Ring of the last 2W+3 pixels: exactly the span one 3x3 window can touch.
  localparam int DEPTH = 2 * W + 3;
  localparam int AW    = $clog2(DEPTH);
  localparam int KW    = $clog2(FILTER_SIZE + 1);
  localparam int GW    = $clog2(ISSUE_GAP + 2);
  localparam int RW    = $clog2(H + 1);
  localparam int CLW   = $clog2(W + 1);
  localparam logic [XW-1:0] NPIX_X  = XW'(NPIX);
  localparam logic [XW-1:0] AHEAD_X = XW'(W + 2);
  localparam logic [AW-1:0] ALAST   = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, TAPS, STREAM} state_t;

  state_t                          state_q, state_d;
  logic [8*FILTER_SIZE-1:0]        taps_q, taps_d;
  logic [KW-1:0]                   tap_q, tap_d;
  logic [CW-1:0]                   in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [RW-1:0]                   row_q, row_d;
  logic [CLW-1:0]                  col_q, col_d;
  logic [AW-1:0]                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [GW-1:0]                   gap_q, gap_d;
  logic [RGB_SIZE*FILTER_SIZE-1:0] data_q, data_d, win;
  logic                            vld_q, vld_d, tc_q, tc_d, done_q, done_d;
  logic [RGB_SIZE-1:0]             mem [DEPTH];
  logic [XW-1:0]                   in_x, out_x, in_eff, ahead, need;
  logic                            stream, accept, issue;

  assign stream    = (state_q == STREAM);
  assign in_x      = XW'(in_cnt_q);
  assign out_x     = XW'(out_cnt_q);
  assign ahead     = out_x + AHEAD_X;
  assign need      = (ahead < NPIX_X) ? ahead : NPIX_X;
  assign pix_ready = stream && (in_x < NPIX_X) && (in_x < ahead);
  assign accept    = pix_valid && pix_ready;
  // The pixel accepted this cycle already counts towards the window it completes.
  assign in_eff    = in_x + XW'(accept);
  assign issue     = stream && (out_x < NPIX_X) && (in_eff >= need) && (gap_q == '0);

  assign input_data = data_q;
  assign valid_dmac = vld_q;
  assign tc_set     = tc_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);

  // Gather the 9 slots for window (row_q, col_q) from the pixel ring, bypassing the pixel written this cycle.
  always_comb begin
    int  dy, dx, rr, cc, a;
    logic in_img;
    win = '0;
    for (int s = 0; s < FILTER_SIZE; s++) begin
      dy = s / 3 - 1;
      dx = s % 3 - 1;
      rr = int'(row_q) + dy;
      cc = int'(col_q) + dx;
`ifdef WIN_BORDER_REPLICATE_EN
      if (rr < 0) rr = 0;
      else if (rr > H - 1) rr = H - 1;
      if (cc < 0) cc = 0;
      else if (cc > W - 1) cc = W - 1;
      in_img = 1'b1;
`else
      in_img = (rr >= 0) && (rr < H) && (cc >= 0) && (cc < W);
`endif
      a = int'(rd_ptr_q) + (rr - int'(row_q)) * W + (cc - int'(col_q));
      if (a < 0) a = a + DEPTH;
      else if (a >= DEPTH) a = a - DEPTH;
      if (in_img) begin
        if (accept && (AW'(a) == wr_ptr_q)) win[RGB_SIZE*s +: RGB_SIZE] = pix_data;
        else                                win[RGB_SIZE*s +: RGB_SIZE] = mem[AW'(a)];
      end
    end
  end

  // Sequencer: tap load, then pixel accept / window issue with forced gap, then done.
  always_comb begin
    state_d   = state_q;
    taps_d    = taps_q;
    tap_d     = tap_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    gap_d     = gap_q;
    data_d    = data_q;
    vld_d     = 1'b0;
    tc_d      = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = TAPS;
          taps_d    = taps;
          tap_d     = KW'(1);
          vld_d     = 1'b1;
          tc_d      = 1'b1;
          data_d    = '0;
          data_d[RGB_SIZE-1:0] = RGB_SIZE'({3{taps[7:0]}});
          in_cnt_d  = '0;
          out_cnt_d = '0;
          row_d     = '0;
          col_d     = '0;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          gap_d     = '0;
        end
      end
      TAPS: begin
        if (tap_q == KW'(FILTER_SIZE)) begin
          state_d = STREAM;
        end else begin
          vld_d  = 1'b1;
          tc_d   = 1'b1;
          data_d = '0;
          data_d[RGB_SIZE-1:0] = RGB_SIZE'({3{taps_q[8*tap_q +: 8]}});
          tap_d  = tap_q + 1'b1;
        end
      end
      STREAM: begin
        if (gap_q != '0) gap_d = gap_q - 1'b1;
        if (accept) begin
          in_cnt_d = in_cnt_q + 1'b1;
          wr_ptr_d = (wr_ptr_q == ALAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (issue) begin
          vld_d     = 1'b1;
          data_d    = win;
          gap_d     = GW'(ISSUE_GAP);
          out_cnt_d = out_cnt_q + 1'b1;
          rd_ptr_d  = (rd_ptr_q == ALAST) ? '0 : rd_ptr_q + 1'b1;
          if (col_q == CLW'(W - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        if (out_x == NPIX_X) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      taps_q    <= '0;
      tap_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      gap_q     <= '0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      tc_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      taps_q    <= taps_d;
      tap_q     <= tap_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      gap_q     <= gap_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      tc_q      <= tc_d;
      done_q    <= done_d;
    end
  end

  // Pixel ring write; contents need no reset since counters gate every read.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= pix_data;
  end
endmodule

// File: tb/tb_fir_window_gen.sv
// Bench for fir_window_gen with a 4x3 slice: fixed vectors, reset abort, randomized frames.
module tb_fir_window_gen;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic         clk = 1'b0;
  logic         rst, start, pix_valid, pix_ready, valid_dmac, tc_set, busy, done;
  logic [71:0]  taps;
  logic [23:0]  pix_data;
  logic [215:0] input_data;

  always #5 clk = ~clk;

  fir_window_gen #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .RGB_SIZE(24), .FILTER_SIZE(9), .ISSUE_GAP(2)) dut (
    .clk(clk), .rst(rst), .start(start), .taps(taps), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .input_data(input_data), .valid_dmac(valid_dmac), .tc_set(tc_set),
    .busy(busy), .done(done)
  );

  typedef struct {
    int          win;   // -1 selects a tap record, slot = tap index
    int          slot;
    logic [23:0] exp;
  } vec_t;

  int           total = 0;
  int           bad = 0;
  logic [23:0]  pix_arr [N];
  logic [215:0] wins_got [$];
  logic [215:0] taps_got [$];
  int           in_obs, out_obs, cyc, last_vld;
  bit           done_seen;
  vec_t         tbl [$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [215:0] model_win(input int idx);
    logic [215:0] w;
    int r, c, rr, cc;
    w = '0;
    r = idx / W;
    c = idx % W;
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
        rr = r - 1 + dy;
        cc = c - 1 + dx;
`ifdef WIN_BORDER_REPLICATE_EN
        rr = (rr < 0) ? 0 : (rr >= H) ? H - 1 : rr;
        cc = (cc < 0) ? 0 : (cc >= W) ? W - 1 : cc;
`endif
        if (rr >= 0 && rr < H && cc >= 0 && cc < W) w[24*(3*dy+dx) +: 24] = pix_arr[rr*W + cc];
      end
    end
    return w;
  endfunction

  task automatic monitor(input bit rnd);
    int  need;
    bit  exp_rdy;
    if (tc_set) check("tc_implies_valid", valid_dmac, 1'b1);
    if (valid_dmac && tc_set) taps_got.push_back(input_data);
    if (valid_dmac && !tc_set) begin
      need = (out_obs + W + 2 < N) ? out_obs + W + 2 : N;
      check("issue_rule", in_obs >= need, 1'b1);
      if (out_obs < N) check("win_data", input_data, model_win(out_obs));
      else check("extra_window", out_obs, N - 1);
      if (last_vld >= 0) begin
        if (rnd) check("gap_min", (cyc - last_vld) >= 3, 1'b1);
        else     check("gap_exact", cyc - last_vld, 3);
      end
      last_vld = cyc;
      wins_got.push_back(input_data);
      out_obs++;
    end
    exp_rdy = busy && !tc_set && (in_obs < N) && (in_obs < out_obs + W + 2);
    check("pix_ready", pix_ready, exp_rdy);
    if (done) begin
      check("done_after_last", cyc - last_vld, 1);
      check("done_count", out_obs, N);
      check("busy_at_done", busy, 1'b0);
      done_seen = 1'b1;
    end
    if (pix_valid && pix_ready) in_obs++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_frame(input logic [71:0] t, input bit rnd, input int abort_at, input int busy_start_at);
    logic [215:0] exp;
    in_obs = 0; out_obs = 0; last_vld = -1; done_seen = 1'b0;
    wins_got.delete();
    taps_got.delete();
    start = 1'b1; taps = t; pix_valid = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 600 && !done_seen; k++) begin
      cyc = k;
      start = (k == busy_start_at);
      if (start) taps = ~t;
      pix_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      pix_data = (pix_valid && in_obs < N) ? pix_arr[in_obs] : 24'($urandom);
      @(negedge clk);
      monitor(rnd);
      @(posedge clk);
      #1;
      if (abort_at > 0 && out_obs >= abort_at) break;
    end
    start = 1'b0;
    pix_valid = 1'b0;
    if (abort_at == 0) begin
      check("frame_done", done_seen, 1'b1);
      check("win_count", out_obs, N);
      check("pix_count", in_obs, N);
      check("tap_count", taps_got.size(), 9);
      for (int k = 0; k < 9; k++) begin
        if (k < taps_got.size()) begin
          exp = '0;
          exp[23:0] = {3{t[8*k +: 8]}};
          check("tap_val", taps_got[k], exp);
        end
      end
    end
  endtask

  task automatic apply_table(input bit only_win0);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].win < 0) begin
        if (!only_win0) begin
          if (tbl[i].slot < taps_got.size()) check("tbl_tap", taps_got[tbl[i].slot], {232'd0, tbl[i].exp});
          else check("tbl_tap_missing", taps_got.size(), tbl[i].slot + 1);
        end
      end else if (!only_win0 || tbl[i].win == 0) begin
        if (tbl[i].win < wins_got.size()) check("tbl_slot", wins_got[tbl[i].win][24*tbl[i].slot +: 24], tbl[i].exp);
        else check("tbl_win_missing", wins_got.size(), tbl[i].win + 1);
      end
    end
  endtask

  initial begin
    int exp0 [9];
    int exp11 [9];
    logic [71:0] rt;
`ifdef WIN_BORDER_REPLICATE_EN
    exp0  = '{1, 1, 2, 1, 1, 2, 5, 5, 6};
    exp11 = '{7, 8, 8, 11, 12, 12, 11, 12, 12};
`else
    exp0  = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
    exp11 = '{7, 8, 0, 11, 12, 0, 0, 0, 0};
`endif
    for (int k = 0; k < 9; k++) tbl.push_back('{-1, k, 24'(32'h010101 * (k + 1))});
    for (int k = 0; k < 9; k++) tbl.push_back('{0, k, 24'(exp0[k])});
    for (int k = 0; k < 9; k++) tbl.push_back('{N - 1, k, 24'(exp11[k])});

    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; taps = '0; pix_data = '0;
    cyc = 0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_pix_ready", pix_ready, 1'b0);
    check("rst_valid", valid_dmac, 1'b0);
    check("rst_tc_set", tc_set, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_data", input_data, 216'd0);
    @(posedge clk);
    #1;

    for (int n = 0; n < N; n++) pix_arr[n] = 24'(n + 1);
    run_frame(72'h090807060504030201, 1'b0, 0, 15);
    apply_table(1'b0);
    idle(2);

    run_frame(72'h090807060504030201, 1'b0, 5, -1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_pix_ready", pix_ready, 1'b0);
    check("abort_valid", valid_dmac, 1'b0);
    check("abort_tc_set", tc_set, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_data", input_data, 216'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_quiet", {valid_dmac, busy}, 2'b00);
    end
    @(posedge clk);
    #1;
    run_frame(72'h090807060504030201, 1'b0, 0, -1);
    apply_table(1'b1);
    idle(2);

    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < N; n++) pix_arr[n] = 24'($urandom);
      rt = 72'({$urandom(), $urandom(), $urandom()});
      run_frame(rt, 1'b1, 0, 30);
      idle($urandom_range(1, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
